// File: rtl/fp_add_control.sv
// Sequencing FSM for the floating-point add/subtract datapath.
// Every control output is a registered Moore output, so the exponent-register load strobe cannot glitch.
module fp_add_control #(
  parameter int MAX_SHIFT = 26,
  parameter int EXP_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub_op,
  input  logic [EXP_W-1:0] saida_registrador,
  input  logic [EXP_W-1:0] tamanhoShift,
  input  logic             directionShift,
  input  logic             overflow,
  output logic             soma_multiplica_small_ula,
  output logic             soma_multiplica_big_ula,
  output logic             subtrador_big_ula,
  output logic [4:0]       tamanho,
  output logic [4:0]       tamanho2,
  output logic [EXP_W-1:0] tamanho3,
  output logic             decisor_mux_expoente_escolhido,
  output logic             decisor_mux_saida_big_ula,
  output logic             decisor_shift_right_left,
  output logic             subtrador_Somador_subtrador,
  output logic             load,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE, DIFF_WAIT, ALIGN, EXP_SET, EXP_PULSE, NORM_SET,
    NORM_PULSE, ROUND_CHECK, OVF_SET, OVF_PULSE, DONE
  } state_t;

  localparam logic [EXP_W-1:0] MaxShiftV = EXP_W'(MAX_SHIFT);
  localparam logic [EXP_W-1:0] OneV      = EXP_W'(1);

  state_t           state_q;
  logic [EXP_W-1:0] diff_q;
  logic             smallSel_q, bigSel_q, subBig_q;
  logic [4:0]       tamanho_q, tamanho2_q;
  logic [EXP_W-1:0] tamanho3_q;
  logic             muxExp_q, muxBig_q, shiftLeft_q, addSub_q;
  logic             load_q, busy_q, done_q;

  logic [EXP_W-1:0] alignAmt, normAmt;

  // Shift amounts saturate at the fraction width instead of wrapping in the 5-bit shifter ports.
  always_comb begin
    alignAmt = (saida_registrador > MaxShiftV) ? MaxShiftV : saida_registrador;
    if (directionShift) begin
      normAmt = OneV;
    end else begin
      normAmt = (tamanhoShift > MaxShiftV) ? MaxShiftV : tamanhoShift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      diff_q      <= '0;
      smallSel_q  <= 1'b1;
      bigSel_q    <= 1'b1;
      subBig_q    <= 1'b0;
      tamanho_q   <= '0;
      tamanho2_q  <= '0;
      tamanho3_q  <= '0;
      muxExp_q    <= 1'b0;
      muxBig_q    <= 1'b0;
      shiftLeft_q <= 1'b0;
      addSub_q    <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            subBig_q <= sub_op;
            busy_q   <= 1'b1;
            state_q  <= DIFF_WAIT;
          end
        end
        DIFF_WAIT: begin
          tamanho_q <= alignAmt[4:0];
          diff_q    <= saida_registrador;
          state_q   <= ALIGN;
        end
        ALIGN: begin
          muxExp_q   <= 1'b0;
          addSub_q   <= 1'b0;
          tamanho3_q <= diff_q;
          load_q     <= 1'b0;
          state_q    <= EXP_SET;
        end
        EXP_SET: begin
          load_q  <= 1'b1;
          state_q <= EXP_PULSE;
        end
        // A carry-out needs a one-place right shift and exponent increment; otherwise normalise left.
        EXP_PULSE: begin
          tamanho2_q  <= normAmt[4:0];
          tamanho3_q  <= normAmt;
          shiftLeft_q <= ~directionShift;
          addSub_q    <= ~directionShift;
          muxExp_q    <= 1'b1;
          muxBig_q    <= 1'b0;
          load_q      <= 1'b0;
          state_q     <= NORM_SET;
        end
        NORM_SET: begin
          load_q  <= 1'b1;
          state_q <= NORM_PULSE;
        end
        NORM_PULSE: begin
          load_q  <= 1'b0;
          state_q <= ROUND_CHECK;
        end
        ROUND_CHECK: begin
          if (overflow) begin
            muxBig_q    <= 1'b1;
            shiftLeft_q <= 1'b0;
            tamanho2_q  <= 5'd1;
            muxExp_q    <= 1'b1;
            addSub_q    <= 1'b0;
            tamanho3_q  <= OneV;
            load_q      <= 1'b0;
            state_q     <= OVF_SET;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        OVF_SET: begin
          load_q  <= 1'b1;
          state_q <= OVF_PULSE;
        end
        OVF_PULSE: begin
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign soma_multiplica_small_ula      = smallSel_q;
  assign soma_multiplica_big_ula        = bigSel_q;
  assign subtrador_big_ula              = subBig_q;
  assign tamanho                        = tamanho_q;
  assign tamanho2                       = tamanho2_q;
  assign tamanho3                       = tamanho3_q;
  assign decisor_mux_expoente_escolhido = muxExp_q;
  assign decisor_mux_saida_big_ula      = muxBig_q;
  assign decisor_shift_right_left       = shiftLeft_q;
  assign subtrador_Somador_subtrador    = addSub_q;
  assign load                           = load_q;
  assign busy                           = busy_q;
  assign done                           = done_q;

endmodule

// File: tb/tb_fp_add_control.sv
// Self-checking bench for fp_add_control: table of operations with expected control sequences,
// plus hand-written reset and start-while-busy sequences.
`timescale 1ns/1ps
module tb_fp_add_control;

  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             reset, start, sub_op, directionShift, overflow;
  logic [EXP_W-1:0] saida_registrador, tamanhoShift;
  logic             soma_multiplica_small_ula, soma_multiplica_big_ula, subtrador_big_ula;
  logic [4:0]       tamanho, tamanho2;
  logic [EXP_W-1:0] tamanho3;
  logic             decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula;
  logic             decisor_shift_right_left, subtrador_Somador_subtrador;
  logic             load, busy, done;

  int errors = 0;
  int checks = 0;

  fp_add_control #(.MAX_SHIFT(26), .EXP_W(EXP_W)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .start                          (start),
    .sub_op                         (sub_op),
    .saida_registrador              (saida_registrador),
    .tamanhoShift                   (tamanhoShift),
    .directionShift                 (directionShift),
    .overflow                       (overflow),
    .soma_multiplica_small_ula      (soma_multiplica_small_ula),
    .soma_multiplica_big_ula        (soma_multiplica_big_ula),
    .subtrador_big_ula              (subtrador_big_ula),
    .tamanho                        (tamanho),
    .tamanho2                       (tamanho2),
    .tamanho3                       (tamanho3),
    .decisor_mux_expoente_escolhido (decisor_mux_expoente_escolhido),
    .decisor_mux_saida_big_ula      (decisor_mux_saida_big_ula),
    .decisor_shift_right_left       (decisor_shift_right_left),
    .subtrador_Somador_subtrador    (subtrador_Somador_subtrador),
    .load                           (load),
    .busy                           (busy),
    .done                           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        subOp;
    logic [7:0]  diff;
    logic [7:0]  tShift;
    logic        dir;
    logic        ovf;
    logic [4:0]  expTamanho;
    logic [7:0]  expT3Exp;
    logic [4:0]  expT2;
    logic [7:0]  expT3Norm;
    logic        expLeft;
    logic        expAddSub;
    logic [15:0] expLoadMask;
    int          expDoneCycle;
  } vec_t;

  vec_t vecs[7];
  vec_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " load"}, 32'(load), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " tamanho"}, 32'(tamanho), 32'd0);
    checkOutput({tag, " tamanho3"}, 32'(tamanho3), 32'd0);
    checkOutput({tag, " smallSel"}, 32'(soma_multiplica_small_ula), 32'd1);
    checkOutput({tag, " bigSel"}, 32'(soma_multiplica_big_ula), 32'd1);
  endtask

  // One full operation; extraStart pulses start during that cycle number (0 = never).
  task automatic applyStimulus(input vec_t v, input int extraStart, input string tag);
    logic [4:0]  obsTam, obsT2, obsT2o;
    logic [7:0]  obsT3e3, obsT3e4, obsT3n, obsT3o;
    logic        obsMuxExp3, obsAddSub3, obsLeft, obsAddSub5, obsMuxExp5, obsMuxBig5, obsSubBig;
    logic        obsMuxBigO, obsLeftO, obsAddSubO, busyBad;
    logic [15:0] loadMask;
    int          cyc, doneCyc;
    vec_t        e;
    obsTam = '0; obsT2 = '0; obsT2o = '0; obsT3e3 = '0; obsT3e4 = '0; obsT3n = '0; obsT3o = '0;
    obsMuxExp3 = 1'b1; obsAddSub3 = 1'b1; obsLeft = 1'b0; obsAddSub5 = 1'b0; obsMuxExp5 = 1'b0;
    obsMuxBig5 = 1'b1; obsSubBig = 1'b0; obsMuxBigO = 1'b0; obsLeftO = 1'b1; obsAddSubO = 1'b1;
    busyBad = 1'b0; loadMask = '0; doneCyc = 0;
    @(negedge clk);
    sub_op = v.subOp; saida_registrador = v.diff; tamanhoShift = v.tShift;
    directionShift = v.dir; overflow = v.ovf; start = 1'b1;
    expQ.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      if (load) loadMask[cyc] = 1'b1;
      if (cyc == 1) obsSubBig = subtrador_big_ula;
      if (cyc == 2) obsTam = tamanho;
      if (cyc == 3) begin
        obsT3e3 = tamanho3; obsMuxExp3 = decisor_mux_expoente_escolhido;
        obsAddSub3 = subtrador_Somador_subtrador;
      end
      if (cyc == 4) obsT3e4 = tamanho3;
      if (cyc == 5) begin
        obsT2 = tamanho2; obsT3n = tamanho3; obsLeft = decisor_shift_right_left;
        obsAddSub5 = subtrador_Somador_subtrador; obsMuxExp5 = decisor_mux_expoente_escolhido;
        obsMuxBig5 = decisor_mux_saida_big_ula;
      end
      if (cyc == 8) begin
        obsMuxBigO = decisor_mux_saida_big_ula; obsT2o = tamanho2; obsT3o = tamanho3;
        obsLeftO = decisor_shift_right_left; obsAddSubO = subtrador_Somador_subtrador;
      end
      if (done) begin
        doneCyc = cyc;
        if (busy) busyBad = 1'b1;
        break;
      end
      if (!busy) busyBad = 1'b1;
      start = (cyc == extraStart);
      @(posedge clk); #1;
      cyc++;
    end
    start = (extraStart != 0 && extraStart == doneCyc);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
    if (load) loadMask[cyc + 1] = 1'b1;
    repeat (3) begin
      checkOutput({tag, " idle after done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    e = expQ.pop_front();
    checkOutput({tag, " subBig"}, 32'(obsSubBig), 32'(e.subOp));
    checkOutput({tag, " tamanho"}, 32'(obsTam), 32'(e.expTamanho));
    checkOutput({tag, " tamanho3 exp c3"}, 32'(obsT3e3), 32'(e.expT3Exp));
    checkOutput({tag, " tamanho3 exp c4"}, 32'(obsT3e4), 32'(e.expT3Exp));
    checkOutput({tag, " muxExp c3"}, 32'(obsMuxExp3), 32'd0);
    checkOutput({tag, " addSub c3"}, 32'(obsAddSub3), 32'd0);
    checkOutput({tag, " tamanho2"}, 32'(obsT2), 32'(e.expT2));
    checkOutput({tag, " tamanho3 norm"}, 32'(obsT3n), 32'(e.expT3Norm));
    checkOutput({tag, " shiftLeft"}, 32'(obsLeft), 32'(e.expLeft));
    checkOutput({tag, " addSub norm"}, 32'(obsAddSub5), 32'(e.expAddSub));
    checkOutput({tag, " muxExp norm"}, 32'(obsMuxExp5), 32'd1);
    checkOutput({tag, " muxBig norm"}, 32'(obsMuxBig5), 32'd0);
    checkOutput({tag, " load mask"}, 32'(loadMask), 32'(e.expLoadMask));
    checkOutput({tag, " done cycle"}, 32'(doneCyc), 32'(e.expDoneCycle));
    checkOutput({tag, " busy profile"}, 32'(busyBad), 32'd0);
    if (e.ovf) begin
      checkOutput({tag, " ovf muxBig"}, 32'(obsMuxBigO), 32'd1);
      checkOutput({tag, " ovf tamanho2"}, 32'(obsT2o), 32'd1);
      checkOutput({tag, " ovf tamanho3"}, 32'(obsT3o), 32'd1);
      checkOutput({tag, " ovf shiftLeft"}, 32'(obsLeftO), 32'd0);
      checkOutput({tag, " ovf addSub"}, 32'(obsAddSubO), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //                subOp diff    tShift dir   ovf   tam    t3Exp   t2     t3Norm left  addSub loadMask   done
    vecs[0] = '{1'b0, 8'd3,   8'd2,   1'b0, 1'b0, 5'd3,  8'd3,   5'd2,  8'd2,  1'b1, 1'b1, 16'h0050, 8};
    vecs[1] = '{1'b0, 8'd5,   8'd0,   1'b1, 1'b0, 5'd5,  8'd5,   5'd1,  8'd1,  1'b0, 1'b0, 16'h0050, 8};
    vecs[2] = '{1'b1, 8'd1,   8'd4,   1'b0, 1'b1, 5'd1,  8'd1,   5'd4,  8'd4,  1'b1, 1'b1, 16'h0250, 10};
    vecs[3] = '{1'b0, 8'd40,  8'd30,  1'b0, 1'b0, 5'd26, 8'd40,  5'd26, 8'd26, 1'b1, 1'b1, 16'h0050, 8};
    vecs[4] = '{1'b1, 8'd26,  8'd27,  1'b0, 1'b0, 5'd26, 8'd26,  5'd26, 8'd26, 1'b1, 1'b1, 16'h0050, 8};
    vecs[5] = '{1'b1, 8'd0,   8'd31,  1'b1, 1'b1, 5'd0,  8'd0,   5'd1,  8'd1,  1'b0, 1'b0, 16'h0250, 10};
    vecs[6] = '{1'b0, 8'd255, 8'd255, 1'b0, 1'b0, 5'd26, 8'd255, 5'd26, 8'd26, 1'b1, 1'b1, 16'h0050, 8};

    reset = 1'b1; start = 1'b0; sub_op = 1'b0; directionShift = 1'b0; overflow = 1'b0;
    saida_registrador = '0; tamanhoShift = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("power-on reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], 0, $sformatf("vec%0d", i));

    // Mid-idle reset must clear the held alignment amount left by the last operation.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("idle reset");
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(vecs[0], 3, "start at c3");
    applyStimulus(vecs[2], 10, "start in DONE");

    // Reset while load is high in NORM_PULSE.
    @(negedge clk);
    sub_op = 1'b0; saida_registrador = 8'd7; tamanhoShift = 8'd3;
    directionShift = 1'b0; overflow = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("norm pulse load before reset", 32'(load), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkResetState("reset in NORM_PULSE");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("idle after pulse reset", 32'(busy | done | load), 32'd0);
    end
    applyStimulus(vecs[1], 0, "after pulse reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_control.md
Name: fp_add_control

Overview:
- Control unit (FSM) that sequences the floating-point add/subtract datapath for one operation per start request.
- Drives every datapath control input and produces the pulsed `load` strobe that updates the rounding-stage exponent register.
- Reads the datapath status outputs: registered exponent difference, normalisation shift count, carry direction and rounding overflow.
- Sits between the system-level requester (start/done handshake) and the datapath.

Parameters:
MAX_SHIFT, 26, saturation limit applied to any fraction shift amount (equals the internal fraction width).
EXP_W, 8, exponent and shift-count width.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub_op  input  1  0 = effective addition, 1 = effective subtraction; latched when start is accepted
saida_registrador  input  EXP_W  registered exponent difference from the small ULA
tamanhoShift  input  EXP_W  leading-zero count of the big-ULA result
directionShift  input  1  big-ULA carry-out (1 = result needs right shift by 1)
overflow  input  1  rounding produced a mantissa carry
soma_multiplica_small_ula  output  1  small-ULA subtract select
soma_multiplica_big_ula  output  1  big-ULA add-path select
subtrador_big_ula  output  1  big-ULA subtract
tamanho  output  5  alignment right-shift amount
tamanho2  output  5  normalisation shift amount
tamanho3  output  EXP_W  exponent increment/decrement amount
decisor_mux_expoente_escolhido  output  1  0 = selected input exponent, 1 = rounded exponent
decisor_mux_saida_big_ula  output  1  0 = big-ULA result, 1 = rounded fraction
decisor_shift_right_left  output  1  1 = shift left, 0 = shift right
subtrador_Somador_subtrador  output  1  exponent adder: 0 = add, 1 = subtract
load  output  1  exponent-register strobe, glitch-free
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (`clk`); reset (`reset`) is synchronous and active-high.
- Output timing: all outputs are registered Moore outputs, so `load` never glitches.
- Reset: state = IDLE. All outputs = 0, except `soma_multiplica_small_ula` = 1 and `soma_multiplica_big_ula` = 1. Reset in any state, including while `load` = 1, forces these values on the next edge.
- IDLE: `busy` = 0. Start handling:
  - `start` = 1 latches `sub_op` into `subtrador_big_ula`, sets `busy` = 1 and moves to DIFF_WAIT.
  - The edge that samples `start` is cycle 0.
- DIFF_WAIT (cycle 1): waits for the registered exponent difference to become valid.
- ALIGN (cycle 2): `tamanho` = min(`saida_registrador`, MAX_SHIFT); the difference is also latched as `diff_r`.
- EXP_SET (cycle 3):
  - `decisor_mux_expoente_escolhido` = 0, `subtrador_Somador_subtrador` = 0.
  - `tamanho3` = `diff_r` (smaller exponent + difference = result exponent).
  - `load` = 0.
- EXP_PULSE (cycle 4): `load` = 1; all other controls unchanged.
- NORM_SET (cycle 5): latch `tamanhoShift` and `directionShift`, then drive:
  - If `directionShift` = 1: shift amount = 1, `decisor_shift_right_left` = 0, `subtrador_Somador_subtrador` = 0.
  - Else: shift amount = min(`tamanhoShift`, MAX_SHIFT), `decisor_shift_right_left` = 1, `subtrador_Somador_subtrador` = 1.
  - `tamanho2` = shift amount[4:0]; `tamanho3` = shift amount.
  - `decisor_mux_expoente_escolhido` = 1, `decisor_mux_saida_big_ula` = 0, `load` = 0.
- NORM_PULSE (cycle 6): `load` = 1.
- ROUND_CHECK (cycle 7): `load` = 0; sample `overflow`.
  - `overflow` = 1 goes to OVF_SET.
  - `overflow` = 0 goes to DONE.
- OVF_SET (cycle 8): `decisor_mux_saida_big_ula` = 1, `decisor_shift_right_left` = 0, `tamanho2` = 1, `decisor_mux_expoente_escolhido` = 1, `subtrador_Somador_subtrador` = 0, `tamanho3` = 1, `load` = 0.
- OVF_PULSE (cycle 9): `load` = 1, then go to DONE.
- DONE: `done` = 1 and `busy` = 0 for exactly one cycle, then IDLE.
  - `done` occurs in cycle 8 without overflow, cycle 10 with overflow.
  - A `start` during DONE is ignored.
- Control hold: controls not named for a state hold their previous values. `tamanho` holds from ALIGN until the next accepted `start`.
- `load` timing: `load` is high only in *_PULSE states, always preceded and followed by at least one `load` = 0 cycle.
- `start` while `busy` = 1: ignored, with no queuing.
- Saturation: any input > MAX_SHIFT is clamped to MAX_SHIFT, never wrapped mod 32.

Test Plan:
- Reset: hold `reset` 2 cycles mid-idle -> `load` = 0, `busy` = 0, `done` = 0, `tamanho` = 0, both ULA selects = 1.
- Add, no overflow: `start` with `sub_op` = 0, `saida_registrador` = 3, `tamanhoShift` = 2, `directionShift` = 0, `overflow` = 0 -> `tamanho` = 3 at cycle 2; `tamanho3` = 3 during cycles 3-4; in normalisation `tamanho2` = 2, `tamanho3` = 2, `decisor_shift_right_left` = 1, `subtrador_Somador_subtrador` = 1; `load` high only in cycles 4 and 6; `done` at cycle 8.
- Carry-out: `directionShift` = 1, `tamanhoShift` = 0 -> `tamanho2` = 1, `tamanho3` = 1, `decisor_shift_right_left` = 0, `subtrador_Somador_subtrador` = 0.
- Rounding overflow: `overflow` = 1 at cycle 7 -> `decisor_mux_saida_big_ula` = 1, `tamanho2` = 1, `tamanho3` = 1, `subtrador_Somador_subtrador` = 0; `load` high in cycle 9; `done` at cycle 10.
- Saturation: `saida_registrador` = 40, `tamanhoShift` = 30 -> `tamanho` = 26, `tamanho2` = 26, `tamanho3` = 26.
- Reset during NORM_PULSE plus `start` while busy: `load` = 0 and IDLE on the next edge; a `start` pulse at cycle 3 of a running operation does not change state or extend latency.
